// File: rtl/fifo_circular_umbral_if.sv
// Handshake bundle for fifo_circular_umbral: write/read requests, data,
// thresholds, occupancy and status flags. master drives, slave is the FIFO.
interface fifo_circular_umbral_if #(
    parameter int LENGTH = 32,
    parameter int SIZE   = 8
);
    localparam int CW = $clog2(LENGTH + 1);

    logic            CLEAR_N;
    logic [SIZE-1:0] DATA_IN;
    logic            WRITE;
    logic            READ;
    logic [CW-1:0]   AF_LEVEL;
    logic [CW-1:0]   AE_LEVEL;
    logic [SIZE-1:0] DATA_OUT;
    logic [CW-1:0]   USE_DW;
    logic            F_FULL_N;
    logic            F_EMPTY_N;
    logic            F_ALMOST_FULL_N;
    logic            F_ALMOST_EMPTY_N;
    logic            OVERFLOW;
    logic            UNDERFLOW;

    modport master (
        output CLEAR_N, DATA_IN, WRITE, READ, AF_LEVEL, AE_LEVEL,
        input  DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N,
        input  F_ALMOST_FULL_N, F_ALMOST_EMPTY_N, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR_N, DATA_IN, WRITE, READ, AF_LEVEL, AE_LEVEL,
        output DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N,
        output F_ALMOST_FULL_N, F_ALMOST_EMPTY_N, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_circular_umbral.sv
// Circular-buffer FIFO, any depth >= 2, with occupancy count, runtime
// almost-full/almost-empty thresholds and sticky overflow/underflow.
// Ports: CLOCK, RESET (async, active-high), bus (slave modport: CLEAR_N,
// DATA_IN, WRITE, READ, AF_LEVEL, AE_LEVEL in; DATA_OUT, USE_DW, flags out).
// Macro FIFO_FWFT_EN selects first-word fall-through output.
module fifo_circular_umbral #(
    parameter int LENGTH = 32,
    parameter int SIZE   = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    fifo_circular_umbral_if.slave bus
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam int PW = $clog2(LENGTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(LENGTH);

    typedef enum logic [1:0] {
        VACIO,
        OTROS,
        LLENO
    } state_t;

    logic [SIZE-1:0] mem [LENGTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf_q;
    logic            unf_q;

    state_t          state;
    logic            do_wr;
    logic            do_rd;
    logic            ovf_set;
    logic            unf_set;
    logic [CW-1:0]   count_nx;
    logic [PW-1:0]   wr_ptr_nx;
    logic [PW-1:0]   rd_ptr_nx;

`ifndef FIFO_FWFT_EN
    logic            bypass;
    logic [SIZE-1:0] dout_q;
`endif

    // Occupancy is the state: empty, in between, full.
    always_comb begin
        state   = OTROS;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
`ifndef FIFO_FWFT_EN
        bypass  = 1'b0;
`endif
        if (count == '0)
            state = VACIO;
        else if (count == CNT_FULL)
            state = LLENO;

        unique case (state)
            VACIO: begin
`ifdef FIFO_FWFT_EN
                // No bypass: the word lands in memory, the read is an error.
                do_wr   = bus.WRITE;
                unf_set = bus.READ;
`else
                bypass  = bus.READ && bus.WRITE;
                do_wr   = bus.WRITE && !bus.READ;
                unf_set = bus.READ && !bus.WRITE;
`endif
            end
            LLENO: begin
                // A simultaneous read frees the slot the write reuses.
                do_rd   = bus.READ;
                do_wr   = bus.WRITE && bus.READ;
                ovf_set = bus.WRITE && !bus.READ;
            end
            default: begin
                do_wr = bus.WRITE;
                do_rd = bus.READ;
            end
        endcase

        unique case ({do_wr, do_rd})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase

        wr_ptr_nx = wr_ptr;
        if (do_wr)
            wr_ptr_nx = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

        rd_ptr_nx = rd_ptr;
        if (do_rd)
            rd_ptr_nx = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
`ifndef FIFO_FWFT_EN
            dout_q <= '0;
`endif
        end else if (!bus.CLEAR_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
`ifndef FIFO_FWFT_EN
            dout_q <= '0;
`endif
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;
            if (ovf_set)
                ovf_q <= 1'b1;
            if (unf_set)
                unf_q <= 1'b1;
`ifndef FIFO_FWFT_EN
            if (do_rd)
                dout_q <= mem[rd_ptr];
            else if (bypass)
                dout_q <= bus.DATA_IN;
`endif
        end
    end

    // Storage is never cleared; only pointers are.
    always_ff @(posedge CLOCK) begin
        if (!RESET && bus.CLEAR_N && do_wr)
            mem[wr_ptr] <= bus.DATA_IN;
    end

`ifdef FIFO_FWFT_EN
    assign bus.DATA_OUT = (count == '0) ? '0 : mem[rd_ptr];
`else
    assign bus.DATA_OUT = dout_q;
`endif

    assign bus.USE_DW           = count;
    assign bus.F_FULL_N         = (count != CNT_FULL);
    assign bus.F_EMPTY_N        = (count != '0);
    assign bus.F_ALMOST_FULL_N  = !(count >= bus.AF_LEVEL);
    assign bus.F_ALMOST_EMPTY_N = !(count <= bus.AE_LEVEL);
    assign bus.OVERFLOW         = ovf_q;
    assign bus.UNDERFLOW        = unf_q;
endmodule

// File: tb/tb_fifo_circular_umbral.sv
// Directed bench for fifo_circular_umbral, standard (registered read) mode,
// LENGTH=4, SIZE=8, with immediate-assertion checks.
module tb_fifo_circular_umbral;
    localparam int LENGTH = 4;
    localparam int SIZE   = 8;

    logic CLOCK;
    logic RESET;
    int   total;
    int   bad;

    fifo_circular_umbral_if #(.LENGTH(LENGTH), .SIZE(SIZE)) bus ();

    fifo_circular_umbral #(.LENGTH(LENGTH), .SIZE(SIZE)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bus.WRITE   = w;
        bus.READ    = r;
        bus.DATA_IN = d;
        @(posedge CLOCK);
        #1;
        bus.WRITE = 1'b0;
        bus.READ  = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        total        = 0;
        bad          = 0;
        RESET        = 1'b1;
        bus.CLEAR_N  = 1'b1;
        bus.WRITE    = 1'b0;
        bus.READ     = 1'b0;
        bus.DATA_IN  = '0;
        bus.AF_LEVEL = 3'd3;
        bus.AE_LEVEL = 3'd1;
        #12;
        RESET = 1'b0;
        #1;

        chk("rst_use", 32'(bus.USE_DW), 0);
        chk("rst_empty_n", 32'(bus.F_EMPTY_N), 0);
        chk("rst_full_n", 32'(bus.F_FULL_N), 1);
        chk("rst_ae_n", 32'(bus.F_ALMOST_EMPTY_N), 0);
        chk("rst_af_n", 32'(bus.F_ALMOST_FULL_N), 1);
        chk("rst_dout", 32'(bus.DATA_OUT), 0);
        chk("rst_ovf", 32'(bus.OVERFLOW), 0);
        chk("rst_unf", 32'(bus.UNDERFLOW), 0);

        // 1: fill and drain
        cyc(1, 0, 8'h11);
        chk("w1_use", 32'(bus.USE_DW), 1);
        chk("w1_ae_n", 32'(bus.F_ALMOST_EMPTY_N), 0);
        cyc(1, 0, 8'h22);
        chk("w2_use", 32'(bus.USE_DW), 2);
        chk("w2_ae_n", 32'(bus.F_ALMOST_EMPTY_N), 1);
        chk("w2_af_n", 32'(bus.F_ALMOST_FULL_N), 1);
        cyc(1, 0, 8'h33);
        chk("w3_use", 32'(bus.USE_DW), 3);
        chk("w3_af_n", 32'(bus.F_ALMOST_FULL_N), 0);
        chk("w3_full_n", 32'(bus.F_FULL_N), 1);
        cyc(1, 0, 8'h44);
        chk("w4_use", 32'(bus.USE_DW), 4);
        chk("w4_full_n", 32'(bus.F_FULL_N), 0);
        cyc(0, 1, 0);
        chk("r1_dout", 32'(bus.DATA_OUT), 32'h11);
        cyc(0, 1, 0);
        chk("r2_dout", 32'(bus.DATA_OUT), 32'h22);
        cyc(0, 1, 0);
        chk("r3_dout", 32'(bus.DATA_OUT), 32'h33);
        cyc(0, 1, 0);
        chk("r4_dout", 32'(bus.DATA_OUT), 32'h44);
        chk("r4_empty_n", 32'(bus.F_EMPTY_N), 0);

        // 2: overflow then underflow
        cyc(1, 0, 8'h11);
        cyc(1, 0, 8'h22);
        cyc(1, 0, 8'h33);
        cyc(1, 0, 8'h44);
        cyc(1, 0, 8'h55);
        chk("ovf_flag", 32'(bus.OVERFLOW), 1);
        chk("ovf_use", 32'(bus.USE_DW), 4);
        cyc(0, 1, 0);
        chk("ovf_r1", 32'(bus.DATA_OUT), 32'h11);
        cyc(0, 1, 0);
        chk("ovf_r2", 32'(bus.DATA_OUT), 32'h22);
        cyc(0, 1, 0);
        chk("ovf_r3", 32'(bus.DATA_OUT), 32'h33);
        cyc(0, 1, 0);
        chk("ovf_r4", 32'(bus.DATA_OUT), 32'h44);
        chk("unf_pre", 32'(bus.UNDERFLOW), 0);
        cyc(0, 1, 0);
        chk("unf_flag", 32'(bus.UNDERFLOW), 1);
        chk("unf_dout", 32'(bus.DATA_OUT), 32'h44);
        chk("ovf_sticky", 32'(bus.OVERFLOW), 1);

        bus.CLEAR_N = 1'b0;
        cyc(0, 0, 0);
        bus.CLEAR_N = 1'b1;
        chk("clr_ovf", 32'(bus.OVERFLOW), 0);
        chk("clr_unf", 32'(bus.UNDERFLOW), 0);

        // 3: wrap-around
        for (int i = 1; i <= 10; i++) begin
            v = 8'(i);
            cyc(1, 0, v);
            cyc(0, 1, 0);
            chk("wrap_dout", 32'(bus.DATA_OUT), 32'(i));
        end
        chk("wrap_use", 32'(bus.USE_DW), 0);

        // 4: simultaneous read and write
        cyc(1, 1, 8'h77);
        chk("byp_dout", 32'(bus.DATA_OUT), 32'h77);
        chk("byp_use", 32'(bus.USE_DW), 0);
        chk("byp_unf", 32'(bus.UNDERFLOW), 0);
        cyc(1, 0, 8'hA1);
        cyc(1, 0, 8'hA2);
        cyc(1, 0, 8'hA3);
        cyc(1, 0, 8'hA4);
        cyc(1, 1, 8'h88);
        chk("frw_use", 32'(bus.USE_DW), 4);
        chk("frw_ovf", 32'(bus.OVERFLOW), 0);
        chk("frw_dout", 32'(bus.DATA_OUT), 32'hA1);
        cyc(0, 1, 0);
        chk("frw_r2", 32'(bus.DATA_OUT), 32'hA2);
        cyc(0, 1, 0);
        chk("frw_r3", 32'(bus.DATA_OUT), 32'hA3);
        cyc(0, 1, 0);
        chk("frw_r4", 32'(bus.DATA_OUT), 32'hA4);
        cyc(0, 1, 0);
        chk("frw_r5", 32'(bus.DATA_OUT), 32'h88);

        // 5: async reset and sync clear mid-operation
        cyc(0, 1, 0);
        chk("mr_unf", 32'(bus.UNDERFLOW), 1);
        cyc(1, 0, 8'hB1);
        cyc(1, 0, 8'hB2);
        chk("mr_use", 32'(bus.USE_DW), 2);
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_use", 32'(bus.USE_DW), 0);
        chk("ar_dout", 32'(bus.DATA_OUT), 0);
        chk("ar_unf", 32'(bus.UNDERFLOW), 0);
        chk("ar_empty_n", 32'(bus.F_EMPTY_N), 0);
        RESET = 1'b0;
        cyc(1, 0, 8'hC1);
        cyc(1, 0, 8'hC2);
        cyc(0, 1, 0);
        chk("sc_dout_pre", 32'(bus.DATA_OUT), 32'hC1);
        bus.CLEAR_N = 1'b0;
        #1;
        chk("sc_use_pre", 32'(bus.USE_DW), 1);
        cyc(0, 0, 0);
        bus.CLEAR_N = 1'b1;
        chk("sc_use", 32'(bus.USE_DW), 0);
        chk("sc_dout", 32'(bus.DATA_OUT), 0);
        cyc(1, 0, 8'hD1);
        cyc(0, 1, 0);
        chk("sc_new", 32'(bus.DATA_OUT), 32'hD1);
        chk("sc_new_use", 32'(bus.USE_DW), 0);

        // 6: runtime thresholds
        cyc(1, 0, 8'hE1);
        cyc(1, 0, 8'hE2);
        chk("th_af_n3", 32'(bus.F_ALMOST_FULL_N), 1);
        bus.AF_LEVEL = 3'd2;
        #1;
        chk("th_af_n2", 32'(bus.F_ALMOST_FULL_N), 0);
        chk("th_ae_n1", 32'(bus.F_ALMOST_EMPTY_N), 1);
        bus.AE_LEVEL = 3'd2;
        #1;
        chk("th_ae_n2", 32'(bus.F_ALMOST_EMPTY_N), 0);
        bus.AF_LEVEL = 3'd0;
        bus.AE_LEVEL = 3'd1;
        #1;
        chk("th_af_n0", 32'(bus.F_ALMOST_FULL_N), 0);
        chk("th_ae_back", 32'(bus.F_ALMOST_EMPTY_N), 1);
        bus.AE_LEVEL = 3'd4;
        cyc(1, 0, 8'hE3);
        cyc(1, 0, 8'hE4);
        chk("th_ae_full", 32'(bus.F_ALMOST_EMPTY_N), 0);
        chk("th_full_n", 32'(bus.F_FULL_N), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
